// File: rtl/sram_responder.sv
// Single-port SRAM responder with a configurable read-latency pipeline.
// Optional access counters RD_CNT/WR_CNT are built when SRAM_STATS_EN is defined.
module sram_responder #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DI,
    input  logic              EN,
    input  logic              WE,
    output logic [DATA_W-1:0] DO,
`ifdef SRAM_STATS_EN
    output logic [31:0]       RD_CNT,
    output logic [31:0]       WR_CNT,
`endif
    output logic              DO_VALID
);

    localparam int DEPTH = 1 << ADDR_W;

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("sram_responder: READ_LATENCY must be 1..4");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              rd_acc;
    logic              wr_acc;
    logic [DATA_W-1:0] rd_word;

    // Reset has priority: nothing is accepted on a reset edge.
    assign rd_acc  = ~reset & EN & ~WE;
    assign wr_acc  = ~reset & EN & WE;
    assign rd_word = mem[ADDR];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[ADDR] <= DI;
        end
    end

    logic              out_v_d;
    logic [DATA_W-1:0] out_d_d;

    if (READ_LATENCY == 1) begin : g_direct
        assign out_v_d = rd_acc;
        assign out_d_d = rd_word;
    end else begin : g_pipe
        localparam int S = READ_LATENCY - 1;

        logic [S-1:0]      v_q;
        logic [DATA_W-1:0] d_q [S];

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q <= '0;
            end else begin
                v_q[0] <= rd_acc;
                for (int i = 1; i < S; i++) begin
                    v_q[i] <= v_q[i-1];
                end
            end
        end

        // Data stages need no reset; the valid bits qualify them.
        always_ff @(posedge clk) begin
            if (rd_acc) begin
                d_q[0] <= rd_word;
            end
            for (int i = 1; i < S; i++) begin
                d_q[i] <= d_q[i-1];
            end
        end

        assign out_v_d = v_q[S-1];
        assign out_d_d = d_q[S-1];
    end

    logic [DATA_W-1:0] do_q;
    logic              do_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            do_q       <= '0;
            do_valid_q <= 1'b0;
        end else begin
            do_valid_q <= out_v_d;
            if (out_v_d) begin
                do_q <= out_d_d;
            end
        end
    end

    assign DO       = do_q;
    assign DO_VALID = do_valid_q;

`ifdef SRAM_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_acc && rd_cnt_q != 32'hFFFF_FFFF) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (wr_acc && wr_cnt_q != 32'hFFFF_FFFF) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign RD_CNT = rd_cnt_q;
    assign WR_CNT = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: four instances (latency 1..4) share one stimulus
// stream; a per-instance scoreboard predicts every DO/DO_VALID cycle.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [31:0] di;
    logic        en;
    logic        we;

    logic [3:0][31:0] dout;
    logic [3:0]       vld;
`ifdef SRAM_STATS_EN
    logic [3:0][31:0] rdc;
    logic [3:0][31:0] wrc;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sram_responder #(
            .ADDR_W      (16),
            .DATA_W      (32),
            .READ_LATENCY(g + 1)
        ) u_dut (
            .clk     (clk),
            .reset   (rst),
            .ADDR    (addr),
            .DI      (di),
            .EN      (en),
            .WE      (we),
            .DO      (dout[g]),
`ifdef SRAM_STATS_EN
            .RD_CNT  (rdc[g]),
            .WR_CNT  (wrc[g]),
`endif
            .DO_VALID(vld[g])
        );
    end

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        r;
        logic        en;
        logic        we;
        logic [15:0] a;
        logic [31:0] d;
        logic        ev;
        logic [31:0] edo;
    } vec_t;

    exp_t        sbq [4][$];
    logic [31:0] last [4];
    logic [31:0] model [65536];
    int          edge_n;
    int          n_chk;
    int          n_fail;
    int          rdm;
    int          wrm;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %h want %h", n, edge_n, act, exp);
        end
    endfunction

    task automatic check_out(input int k);
        exp_t e;
        if (sbq[k].size() > 0 && sbq[k][0].due == edge_n) begin
            e = sbq[k].pop_front();
            chk($sformatf("valid_L%0d", k + 1), {31'd0, vld[k]}, 32'd1);
            chk($sformatf("data_L%0d", k + 1), dout[k], e.data);
            last[k] = e.data;
        end else begin
            chk($sformatf("idle_L%0d", k + 1), {31'd0, vld[k]}, 32'd0);
            chk($sformatf("hold_L%0d", k + 1), dout[k], last[k]);
        end
    endtask

    task automatic step(input logic r, input logic e_, input logic w,
                        input logic [15:0] a, input logic [31:0] d);
        rst  = r;
        en   = e_;
        we   = w;
        addr = a;
        di   = d;
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                sbq[k].delete();
                last[k] = '0;
            end
            rdm = 0;
            wrm = 0;
        end else if (e_ && !w) begin
            for (int k = 0; k < 4; k++) begin
                sbq[k].push_back('{edge_n + k, model[a]});
            end
            rdm++;
        end else if (e_ && w) begin
            model[a] = d;
            wrm++;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check_out(k);
`ifdef SRAM_STATS_EN
            chk($sformatf("rdcnt_L%0d", k + 1), rdc[k], rdm);
            chk($sformatf("wrcnt_L%0d", k + 1), wrc[k], wrm);
`endif
        end
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        end
    endtask

    task automatic rd(input logic [15:0] a);
        step(1'b0, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, a, d);
    endtask

    vec_t tv [16];

    initial begin
        edge_n = 0;
        n_chk  = 0;
        n_fail = 0;
        rdm    = 0;
        wrm    = 0;
        rst    = 1'b1;
        en     = 1'b0;
        we     = 1'b0;
        addr   = '0;
        di     = '0;
        for (int k = 0; k < 4; k++) last[k] = '0;

        // Expected columns are for the latency-1 instance.
        tv[0]  = '{1, 0, 0, 16'h0000, 32'h0, 0, 32'h00};
        tv[1]  = '{0, 1, 1, 16'h0005, 32'hA, 0, 32'h00};
        tv[2]  = '{0, 1, 1, 16'h0006, 32'hB, 0, 32'h00};
        tv[3]  = '{0, 1, 1, 16'h0007, 32'hC, 0, 32'h00};
        tv[4]  = '{0, 1, 0, 16'h0005, 32'h0, 1, 32'h0A};
        tv[5]  = '{0, 1, 0, 16'h0006, 32'h0, 1, 32'h0B};
        tv[6]  = '{0, 1, 0, 16'h0007, 32'h0, 1, 32'h0C};
        tv[7]  = '{0, 0, 0, 16'h0000, 32'h0, 0, 32'h0C};
        tv[8]  = '{0, 0, 0, 16'h0000, 32'h0, 0, 32'h0C};
        tv[9]  = '{0, 1, 1, 16'h0009, 32'h11, 0, 32'h0C};
        tv[10] = '{0, 1, 0, 16'h0009, 32'h0, 1, 32'h11};
        tv[11] = '{0, 1, 1, 16'h0009, 32'h22, 0, 32'h11};
        tv[12] = '{0, 1, 0, 16'h0009, 32'h0, 1, 32'h22};
        tv[13] = '{0, 0, 0, 16'h0000, 32'h0, 0, 32'h22};
        tv[14] = '{0, 0, 0, 16'h0000, 32'h0, 0, 32'h22};
        tv[15] = '{0, 0, 0, 16'h0000, 32'h0, 0, 32'h22};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            step(tv[i].r, tv[i].en, tv[i].we, tv[i].a, tv[i].d);
            chk($sformatf("tv%0d_valid", i), {31'd0, vld[0]}, {31'd0, tv[i].ev});
            chk($sformatf("tv%0d_do", i), dout[0], tv[i].edo);
        end
        idle(3);

        // Reset lands while the latency-4 read is in flight; the write is dropped.
        wr(16'h0030, 32'h1234_5678);
        idle(1);
        rd(16'h0030);
        idle(1);
        step(1'b1, 1'b1, 1'b1, 16'h0030, 32'h0BAD_0BAD);
        chk("rst_do_L4", dout[3], 32'h0);
        idle(5);
        rd(16'h0030);
        idle(4);
        chk("reread_L4", dout[3], 32'h1234_5678);

        // Idle hold with garbage on the address/data/write-enable lines.
        wr(16'hFFFF, 32'hDEAD_BEEF);
        rd(16'hFFFF);
        idle(4);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'($urandom), 16'($urandom), $urandom);
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hold_dead_L%0d", k + 1), dout[k], 32'hDEAD_BEEF);
        end
        rd(16'hFFFF);
        rd(16'h0005);
        rd(16'h0006);
        rd(16'h0007);
        rd(16'h0009);
        rd(16'h0030);
        idle(4);

        // Address sweep over both ends of the array.
        for (int i = 0; i < 2048; i++) begin
            logic [15:0] a;
            a = (i < 1024) ? 16'(i) : 16'(i - 1024 + 16'hFC00);
            wr(a, {~a, a});
            rd(a);
        end
        idle(4);

`ifdef SRAM_STATS_EN
        step(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        wr(16'h0001, 32'h101);
        wr(16'h0002, 32'h102);
        wr(16'h0003, 32'h103);
        rd(16'h0001);
        rd(16'h0002);
        rd(16'h0003);
        rd(16'h0001);
        rd(16'h0002);
        idle(2);
        chk("stats_wr", wrc[0], 32'd3);
        chk("stats_rd", rdc[0], 32'd5);
        step(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        chk("stats_wr_rst", wrc[0], 32'd0);
        chk("stats_rd_rst", rdc[0], 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
